traffic_light_monitor: RTL and testbench

- Passive checker on the light-output side of the highway/small-road intersection controller.
- Samples the two 2-bit light codes and the vehicle sensor, and reconstructs the controller's phase.
- Enforces legal phase ordering, minimum yellow time and sensor-consistent phase changes, and reports a sticky first error.
- Also counts completed service cycles. Used in simulation benches and as an on-chip safety watchdog.

---
 rtl/traffic_light_monitor.sv | 178 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase tracker and safety checker for the intersection light outputs
//
// Purpose: samples the highway / small-road light codes and the small-road
// sensor, reconstructs the controller phase, checks phase ordering, minimum
// yellow time and sensor-consistent phase changes, latches the first error and
// counts completed SY->HG service cycles.
//
// Ports:
//   clk          system clock, rising-edge sampling
//   clr          asynchronous active-high clear
//   highway      highway light code    (0=RED 1=YELLOW 2=GREEN 3=illegal)
//   small_road   small-road light code (same encoding)
//   sensor       small-road vehicle sensor
//   phase        tracked phase (0=INIT 1=HG 2=HY 3=AR 4=SG 5=SY)
//   dwell        cycles spent in current phase, saturating
//   cycle_count  completed SY->HG cycles, wrapping
//   err          sticky error flag
//   err_code     first error (0=none 1=COMBO 2=TRANSITION 3=SHORT_YELLOW 4=SENSOR)

module traffic_light_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       highway,
  input  logic [1:0]       small_road,
  input  logic             sensor,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err,
  output logic [2:0]       err_code
);

  typedef enum logic [2:0] {
    P_INIT = 3'd0,
    P_HG   = 3'd1,
    P_HY   = 3'd2,
    P_AR   = 3'd3,
    P_SG   = 3'd4,
    P_SY   = 3'd5
  } phase_t;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_GREEN  = 2'd2;

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_COMBO  = 3'd1;
  localparam logic [2:0] E_TRANS  = 3'd2;
  localparam logic [2:0] E_SHORT  = 3'd3;
  localparam logic [2:0] E_SENSOR = 3'd4;

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL_ONE = {CNT_W{1'b1}};

  phase_t           state, state_n;
  logic [CNT_W-1:0] dwell_n, cycle_n;
  logic             err_n;
  logic [2:0]       code_n;
  logic             sensor_d;

  // Decoded light pair
  phase_t dec;
  logic   combo_ok;

  always_comb begin
    dec      = P_INIT;
    combo_ok = 1'b1;
    case ({highway, small_road})
      {L_GREEN,  L_RED}:    dec = P_HG;
      {L_YELLOW, L_RED}:    dec = P_HY;
      {L_RED,    L_RED}:    dec = P_AR;
      {L_RED,    L_GREEN}:  dec = P_SG;
      {L_RED,    L_YELLOW}: dec = P_SY;
      default:              combo_ok = 1'b0;
    endcase
  end

  // The only legal successor of each tracked phase
  phase_t succ;

  always_comb begin
    succ = P_INIT;
    case (state)
      P_HG:    succ = P_HY;
      P_HY:    succ = P_AR;
      P_AR:    succ = P_SG;
      P_SG:    succ = P_SY;
      P_SY:    succ = P_HG;
      default: succ = P_INIT;
    endcase
  end

  logic e_combo, e_trans, e_short, e_sensor, any_err;
  logic short_yellow;

  // Widened compare keeps MIN_YELLOW=0 meaningful (never short)
  assign short_yellow = 32'(dwell) < 32'(MIN_YELLOW);

  always_comb begin
    state_n  = state;
    dwell_n  = dwell;
    cycle_n  = cycle_count;
    e_combo  = 1'b0;
    e_trans  = 1'b0;
    e_short  = 1'b0;
    e_sensor = 1'b0;

    if (!combo_ok) begin
      e_combo = 1'b1;
    end else if (state == P_INIT) begin
      // Waiting to resync: only HG gets the tracker going
      if (dec == P_HG) begin
        state_n = P_HG;
        dwell_n = ONE;
      end else begin
        dwell_n = '0;
      end
    end else if (dec == state) begin
      if (dwell != ALL_ONE)
        dwell_n = dwell + ONE;
    end else if (dec == succ) begin
      if ((state == P_HY || state == P_SY) && short_yellow)
        e_short = 1'b1;
      if (state == P_HG && !sensor_d)
        e_sensor = 1'b1;
      if (state == P_SG && sensor_d)
        e_sensor = 1'b1;
      state_n = dec;
      dwell_n = ONE;
      if (state == P_SY)
        cycle_n = cycle_count + ONE;
    end else begin
      e_trans = 1'b1;
    end

    any_err = e_combo | e_trans | e_short | e_sensor;

    if (any_err) begin
      state_n = P_INIT;
      dwell_n = '0;
      cycle_n = cycle_count;
    end

    err_n  = err | any_err;
    code_n = err_code;
    if (!err) begin
      if      (e_combo)  code_n = E_COMBO;
      else if (e_trans)  code_n = E_TRANS;
      else if (e_short)  code_n = E_SHORT;
      else if (e_sensor) code_n = E_SENSOR;
      else               code_n = E_NONE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= P_INIT;
      dwell       <= '0;
      cycle_count <= '0;
      err         <= 1'b0;
      err_code    <= E_NONE;
      sensor_d    <= 1'b0;
    end else begin
      state       <= state_n;
      dwell       <= dwell_n;
      cycle_count <= cycle_n;
      err         <= err_n;
      err_code    <= code_n;
      sensor_d    <= sensor;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed vector bench for traffic_light_monitor

module tb_traffic_light_monitor;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] highway = R;
  logic [1:0] small_road = R;
  logic       sensor = 1'b0;
  logic [2:0] phase;
  logic [7:0] dwell;
  logic [7:0] cycle_count;
  logic       err;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.MIN_YELLOW(2), .CNT_W(8)) dut (
    .clk(clk),
    .clr(clr),
    .highway(highway),
    .small_road(small_road),
    .sensor(sensor),
    .phase(phase),
    .dwell(dwell),
    .cycle_count(cycle_count),
    .err(err),
    .err_code(err_code)
  );

  typedef struct {
    logic [1:0] hw;
    logic [1:0] sr;
    logic       s;
    logic [2:0] ph;
    logic [7:0] dw;
    logic [7:0] cc;
    logic       er;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] hw, input logic [1:0] sr, input logic s,
                     input logic [2:0] ph, input logic [7:0] dw, input logic [7:0] cc,
                     input logic er, input logic [2:0] code);
    vec_t v;
    v.hw = hw; v.sr = sr; v.s = s; v.ph = ph; v.dw = dw; v.cc = cc; v.er = er; v.code = code;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] ph, input logic [7:0] dw,
                       input logic [7:0] cc, input logic er, input logic [2:0] code);
    checks++;
    if ({phase, dwell, cycle_count, err, err_code} !== {ph, dw, cc, er, code}) begin
      errors++;
      $display("FAIL %s: got ph=%0d dw=%0d cc=%0d err=%0d code=%0d, want ph=%0d dw=%0d cc=%0d err=%0d code=%0d",
               name, phase, dwell, cycle_count, err, err_code, ph, dw, cc, er, code);
    end
  endtask

  // Drive one sample, let the rising edge take it, look 1 time unit later
  task automatic step(input logic [1:0] hw, input logic [1:0] sr, input logic s);
    highway = hw;
    small_road = sr;
    sensor = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  initial begin
    // Reset and HG warm-up
    for (int i = 1; i <= 5; i++) add(G, R, 1'b0, 3'd1, 8'(i), 8'd0, 1'b0, 3'd0);
    // Full legal cycle: sensor high in the last HG sample, low before SY
    add(G, R, 1'b1, 3'd1, 8'd6, 8'd0, 1'b0, 3'd0);
    for (int i = 1; i <= 3; i++) add(Y, R, 1'b0, 3'd2, 8'(i), 8'd0, 1'b0, 3'd0);
    for (int i = 1; i <= 2; i++) add(R, R, 1'b0, 3'd3, 8'(i), 8'd0, 1'b0, 3'd0);
    for (int i = 1; i <= 4; i++) add(R, G, 1'b0, 3'd4, 8'(i), 8'd0, 1'b0, 3'd0);
    for (int i = 1; i <= 3; i++) add(R, Y, 1'b0, 3'd5, 8'(i), 8'd0, 1'b0, 3'd0);
    add(G, R, 1'b0, 3'd1, 8'd1, 8'd1, 1'b0, 3'd0);
    // Illegal combo from HG, then resync at HG
    add(G, G, 1'b0, 3'd0, 8'd0, 8'd1, 1'b1, 3'd1);
    add(G, R, 1'b0, 3'd1, 8'd1, 8'd1, 1'b1, 3'd1);

    #1;
    check("reset", 3'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    #3;
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].hw, vecs[i].sr, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].dw, vecs[i].cc, vecs[i].er, vecs[i].code);
    end

    // Async clear in the middle of SG, between edges
    step(G, R, 1'b1);
    step(Y, R, 1'b0);
    step(Y, R, 1'b0);
    step(R, R, 1'b0);
    step(R, G, 1'b0);
    check("pre_clr_sg", 3'd4, 8'd1, 8'd1, 1'b1, 3'd1);
    #3;
    clr = 1'b1;
    #1;
    check("async_clr", 3'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    clr = 1'b0;
    step(R, G, 1'b0);
    check("post_clr_sg_no_err", 3'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    step(G, R, 1'b0);
    check("post_clr_resync", 3'd1, 8'd1, 8'd0, 1'b0, 3'd0);

    // Short yellow
    pulse_clr();
    step(G, R, 1'b1);
    step(Y, R, 1'b0);
    check("short_hy_d1", 3'd2, 8'd1, 8'd0, 1'b0, 3'd0);
    step(R, R, 1'b0);
    check("short_yellow", 3'd0, 8'd0, 8'd0, 1'b1, 3'd3);

    // Sensor mismatch, then a later illegal transition keeps the first code
    pulse_clr();
    step(G, R, 1'b0);
    step(Y, R, 1'b0);
    check("sensor_mismatch", 3'd0, 8'd0, 8'd0, 1'b1, 3'd4);
    step(G, R, 1'b0);
    step(R, G, 1'b0);
    check("first_error_wins", 3'd0, 8'd0, 8'd0, 1'b1, 3'd4);

    // Illegal transition alone
    pulse_clr();
    step(G, R, 1'b0);
    step(R, G, 1'b0);
    check("illegal_transition", 3'd0, 8'd0, 8'd0, 1'b1, 3'd2);

    // SG leaving with sensor still high
    pulse_clr();
    step(G, R, 1'b1);
    step(Y, R, 1'b1);
    step(Y, R, 1'b1);
    step(R, R, 1'b1);
    step(R, G, 1'b1);
    step(R, Y, 1'b0);
    check("sg_sensor_mismatch", 3'd0, 8'd0, 8'd0, 1'b1, 3'd4);

    // Short SY blocks the cycle count
    pulse_clr();
    step(G, R, 1'b1);
    step(Y, R, 1'b0);
    step(Y, R, 1'b0);
    step(R, R, 1'b0);
    step(R, G, 1'b0);
    step(R, Y, 1'b0);
    step(G, R, 1'b0);
    check("short_sy_no_count", 3'd0, 8'd0, 8'd0, 1'b1, 3'd3);

    // Code-3 highway at the same time as an illegal jump: combo wins
    pulse_clr();
    step(G, R, 1'b0);
    step(2'd3, G, 1'b0);
    check("priority_combo", 3'd0, 8'd0, 8'd0, 1'b1, 3'd1);

    // Dwell saturation
    pulse_clr();
    for (int i = 0; i < 300; i++) step(G, R, 1'b0);
    check("dwell_saturate", 3'd1, 8'd255, 8'd0, 1'b0, 3'd0);

    // 256 legal cycles wrap the counter
    pulse_clr();
    step(G, R, 1'b1);
    for (int n = 1; n <= 256; n++) begin
      step(Y, R, 1'b0);
      step(Y, R, 1'b0);
      step(R, R, 1'b0);
      step(R, G, 1'b0);
      step(R, Y, 1'b0);
      step(R, Y, 1'b0);
      step(G, R, 1'b1);
      if (n == 1)   check("cc_1", 3'd1, 8'd1, 8'd1, 1'b0, 3'd0);
      if (n == 255) check("cc_255", 3'd1, 8'd1, 8'd255, 1'b0, 3'd0);
      if (n == 256) check("cc_wrap", 3'd1, 8'd1, 8'd0, 1'b0, 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
